imem_arbiter: RTL and testbench

Shares the single-port, synchronous-read instruction RAM between the pipeline fetch stage and the program loader/debug port.
- After reset it holds the core in a BOOT phase, in which the loader has exclusive access to write the program image.
- It then switches to RUN, where fetch has priority and a starvation counter guarantees the loader a slot.
- It converts byte addresses to word addresses, tags each granted read, and routes the RAM data back to the owner one cycle later.

---
 rtl/imem_arbiter.sv | 133 +++++++++++++
 tb/tb_imem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// imem_arbiter
//   Shares a single-port, synchronous-read instruction RAM between the fetch
//   stage and the program loader/debug port.
//   BOOT: loader has exclusive access until boot_done is seen.
//   RUN : fetch has priority; a starvation counter forces the loader through
//         after STARVE_LIMIT consecutive fetch grants while load_req is held.
//   Each granted read is tagged so the RAM data returned one cycle later is
//   routed to its owner.
//
// Ports:
//   clk, reset                 rising-edge clock, async active-high reset
//   boot_done                  loader image complete (sampled in BOOT only)
//   fetch_req/addr/ready       fetch request, byte address, grant
//   fetch_valid/instr          fetch response (NOP when not valid)
//   load_req/we/addr/wdata     loader request, write enable, byte address, data
//   load_ready                 loader grant
//   load_valid/rdata           loader read response (0 when not valid)
//   mem_en/we/addr/wdata       RAM command (word address)
//   mem_rdata                  RAM read data, valid the cycle after a read
module imem_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              boot_done,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [31:0]       fetch_instr,
    input  logic              load_req,
    input  logic              load_we,
    input  logic [31:0]       load_addr,
    input  logic [31:0]       load_wdata,
    output logic              load_ready,
    output logic              load_valid,
    output logic [31:0]       load_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int          CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic {
        ST_BOOT,
        ST_RUN
    } state_t;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_FETCH,
        TAG_LOAD_RD
    } tag_t;

    state_t            state, state_nx;
    tag_t              resp_tag, tag_nx;
    logic [CNT_W-1:0]  starve_cnt, starve_nx;
    logic              fetch_grant, load_grant, starved;
    logic [ADDR_W-1:0] fetch_waddr, load_waddr;
    logic              unused_addr_bits;

    // Byte offset and bits above the RAM range are dropped.
    assign fetch_waddr = fetch_addr[ADDR_W+1:2];
    assign load_waddr  = load_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{fetch_addr[31:ADDR_W+2], fetch_addr[1:0],
                                load_addr[31:ADDR_W+2], load_addr[1:0]};

    assign starved = load_req && (starve_cnt == LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_BOOT;
            resp_tag   <= TAG_NONE;
            starve_cnt <= '0;
        end else begin
            state      <= state_nx;
            resp_tag   <= tag_nx;
            starve_cnt <= starve_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        starve_nx   = starve_cnt;
        tag_nx      = TAG_NONE;
        fetch_grant = 1'b0;
        load_grant  = 1'b0;
        case (state)
            ST_BOOT: begin
                load_grant = load_req;
                starve_nx  = '0;
                if (boot_done) state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (fetch_req && !starved) fetch_grant = 1'b1;
                else if (load_req)         load_grant  = 1'b1;
                if (load_grant || !load_req)
                    starve_nx = '0;
                else if (fetch_grant && starve_cnt != LIMIT)
                    starve_nx = starve_cnt + CNT_W'(1);
            end
            default: state_nx = ST_BOOT;
        endcase
        // Writes produce no response, so they are recorded as NONE.
        if (fetch_grant)                 tag_nx = TAG_FETCH;
        else if (load_grant && !load_we) tag_nx = TAG_LOAD_RD;
    end

    assign fetch_ready = fetch_grant;
    assign load_ready  = load_grant;

    always_comb begin
        mem_en    = fetch_grant | load_grant;
        mem_we    = load_grant & load_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (fetch_grant)     mem_addr = fetch_waddr;
        else if (load_grant) mem_addr = load_waddr;
        if (fetch_grant || load_grant) mem_wdata = load_wdata;
    end

    assign fetch_valid = (resp_tag == TAG_FETCH);
    assign load_valid  = (resp_tag == TAG_LOAD_RD);
    assign fetch_instr = fetch_valid ? mem_rdata : NOP;
    assign load_rdata  = load_valid  ? mem_rdata : '0;

endmodule

// File: tb/tb_imem_arbiter.sv
module tb_imem_arbiter;

    localparam int          ADDR_W = 10;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              boot_done = 1'b0;
    logic              fetch_req = 1'b0;
    logic [31:0]       fetch_addr = '0;
    logic              fetch_ready, fetch_valid;
    logic [31:0]       fetch_instr;
    logic              load_req = 1'b0;
    logic              load_we = 1'b0;
    logic [31:0]       load_addr = '0;
    logic [31:0]       load_wdata = '0;
    logic              load_ready, load_valid;
    logic [31:0]       load_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = '0;

    logic [31:0] ram [0:(1<<ADDR_W)-1];

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          is_fetch;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] prog [4] = '{32'h00500113, 32'h00A00193, 32'h00310233, 32'h00F02623};

    imem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset), .boot_done(boot_done),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
        .load_req(load_req), .load_we(load_we), .load_addr(load_addr),
        .load_wdata(load_wdata), .load_ready(load_ready), .load_valid(load_valid),
        .load_rdata(load_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM environment model.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // Advance one cycle and compare the response outputs against the scoreboard.
    task automatic tick();
        exp_t        e;
        logic        efv, elv;
        logic [31:0] ein, erd;
        efv = 1'b0; elv = 1'b0; ein = NOP; erd = '0;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.is_fetch) begin efv = 1'b1; ein = e.data; end
            else            begin elv = 1'b1; erd = e.data; end
        end
        @(posedge clk);
        #1;
        checks++;
        if ({fetch_valid, fetch_instr} !== {efv, ein}) begin
            errors++;
            $display("FAIL fetch_resp t=%0t: got valid=%b instr=%h, want valid=%b instr=%h",
                     $time, fetch_valid, fetch_instr, efv, ein);
        end
        checks++;
        if ({load_valid, load_rdata} !== {elv, erd}) begin
            errors++;
            $display("FAIL load_resp t=%0t: got valid=%b rdata=%h, want valid=%b rdata=%h",
                     $time, load_valid, load_rdata, elv, erd);
        end
    endtask

    task automatic idle_inputs();
        fetch_req = 1'b0; load_req = 1'b0; load_we = 1'b0; boot_done = 1'b0;
        fetch_addr = '0; load_addr = '0; load_wdata = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        fetch_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({fetch_valid, load_valid, fetch_instr, load_rdata} !== {1'b0, 1'b0, NOP, 32'h0}) begin
            errors++;
            $display("FAIL reset_outputs: got fv=%b lv=%b instr=%h rdata=%h, want 0 0 %h 0",
                     fetch_valid, load_valid, fetch_instr, load_rdata, NOP);
        end
        checks++;
        if (fetch_ready !== 1'b0 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_boot: got fetch_ready=%b mem_en=%b, want 0 0", fetch_ready, mem_en);
        end
        idle_inputs();
        reset = 1'b0;
    endtask

    task automatic test_boot_writes();
        for (int i = 0; i < 4; i++) begin
            fetch_req = 1'b1; fetch_addr = '0;
            load_req = 1'b1; load_we = 1'b1;
            load_addr = 32'(i * 4); load_wdata = prog[i];
            #1;
            checks++;
            if ({fetch_ready, load_ready, mem_en, mem_we} !== 4'b0111 ||
                mem_addr !== ADDR_W'(i) || mem_wdata !== prog[i]) begin
                errors++;
                $display("FAIL boot_write[%0d]: got fr=%b lr=%b en=%b we=%b addr=%0d wdata=%h, want 0 1 1 1 %0d %h",
                         i, fetch_ready, load_ready, mem_en, mem_we, mem_addr, mem_wdata, i, prog[i]);
            end
            tick();
        end
        load_req = 1'b0; load_we = 1'b0; boot_done = 1'b1;
        #1;
        checks++;
        if (fetch_ready !== 1'b0) begin
            errors++;
            $display("FAIL boot_done_cycle: got fetch_ready=%b, want 0", fetch_ready);
        end
        tick();
        boot_done = 1'b0;
    endtask

    task automatic test_fetch_stream();
        for (int i = 0; i < 3; i++) begin
            fetch_req = 1'b1; fetch_addr = 32'(i * 4);
            #1;
            checks++;
            if ({fetch_ready, mem_en, mem_we} !== 3'b110 || mem_addr !== ADDR_W'(i)) begin
                errors++;
                $display("FAIL fetch_grant[%0d]: got fr=%b en=%b we=%b addr=%0d, want 1 1 0 %0d",
                         i, fetch_ready, mem_en, mem_we, mem_addr, i);
            end
            exp_q.push_back('{1'b1, prog[i]});
            tick();
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_starvation();
        fetch_req = 1'b1; fetch_addr = 32'h0;
        load_req = 1'b1; load_we = 1'b0; load_addr = 32'hC;
        for (int round = 0; round < 2; round++) begin
            for (int k = 0; k < 4; k++) begin
                #1;
                checks++;
                if ({fetch_ready, load_ready} !== 2'b10) begin
                    errors++;
                    $display("FAIL starve_fetch[%0d.%0d]: got fr=%b lr=%b, want 1 0",
                             round, k, fetch_ready, load_ready);
                end
                exp_q.push_back('{1'b1, prog[0]});
                tick();
            end
            #1;
            checks++;
            if ({fetch_ready, load_ready, mem_we} !== 3'b010 || mem_addr !== ADDR_W'(3)) begin
                errors++;
                $display("FAIL starve_load[%0d]: got fr=%b lr=%b we=%b addr=%0d, want 0 1 0 3",
                         round, fetch_ready, load_ready, mem_we, mem_addr);
            end
            exp_q.push_back('{1'b0, prog[3]});
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_byte_offset();
        logic [31:0] addrs [2] = '{32'h0000_000B, 32'h8000_100B};
        for (int i = 0; i < 2; i++) begin
            fetch_req = 1'b1; fetch_addr = addrs[i];
            #1;
            checks++;
            if (fetch_ready !== 1'b1 || mem_addr !== ADDR_W'(2)) begin
                errors++;
                $display("FAIL byte_offset[%0d]: got fr=%b addr=%0d, want 1 2", i, fetch_ready, mem_addr);
            end
            exp_q.push_back('{1'b1, prog[2]});
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_write_read();
        load_req = 1'b1; load_we = 1'b1; load_addr = 32'h10; load_wdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if ({load_ready, mem_we} !== 2'b11 || mem_addr !== ADDR_W'(4) || mem_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL wr_grant: got lr=%b we=%b addr=%0d wdata=%h, want 1 1 4 deadbeef",
                     load_ready, mem_we, mem_addr, mem_wdata);
        end
        tick();
        load_we = 1'b0; load_wdata = '0;
        #1;
        checks++;
        if ({load_ready, mem_en, mem_we} !== 3'b110 || mem_addr !== ADDR_W'(4)) begin
            errors++;
            $display("FAIL rd_grant: got lr=%b en=%b we=%b addr=%0d, want 1 1 0 4",
                     load_ready, mem_en, mem_we, mem_addr);
        end
        exp_q.push_back('{1'b0, 32'hDEAD_BEEF});
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_read();
        fetch_req = 1'b1; fetch_addr = 32'h4;
        #1;
        checks++;
        if (fetch_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_grant: got fetch_ready=%b, want 1", fetch_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({fetch_valid, fetch_instr, fetch_ready} !== {1'b0, NOP, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: got fv=%b instr=%h fr=%b, want 0 %h 0",
                     fetch_valid, fetch_instr, fetch_ready, NOP);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (fetch_ready !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_block[%0d]: got fetch_ready=%b, want 0", i, fetch_ready);
            end
            tick();
        end
        boot_done = 1'b1;
        tick();
        boot_done = 1'b0;
        #1;
        checks++;
        if (fetch_ready !== 1'b1 || mem_addr !== ADDR_W'(1)) begin
            errors++;
            $display("FAIL reboot_fetch: got fr=%b addr=%0d, want 1 1", fetch_ready, mem_addr);
        end
        exp_q.push_back('{1'b1, prog[1]});
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_idle();
        idle_inputs();
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if ({mem_en, mem_we, fetch_ready, load_ready} !== 4'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
                errors++;
                $display("FAIL idle_mem[%0d]: got en=%b we=%b fr=%b lr=%b addr=%0d wdata=%h, want all 0",
                         i, mem_en, mem_we, fetch_ready, load_ready, mem_addr, mem_wdata);
            end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = '0;
        test_reset();
        test_boot_writes();
        test_fetch_stream();
        test_starvation();
        test_byte_offset();
        test_write_read();
        test_reset_mid_read();
        test_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
